icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache.
- Services line requests from the instruction fetch queue and returns one 128-bit line (4 instructions) per request.
- On a miss it refills the line from main memory, one 32-bit word per memory transaction.
- It is the responder end of the fetch-queue/icache interface (pc_in, rd_en, abort, dout, dout_valid).

Parameters:
- INDEX_BITS, 6, line index width; the cache holds 2**INDEX_BITS lines of 16 bytes each.
- TAG_BITS, 28-INDEX_BITS, derived tag width (pc[31:4+INDEX_BITS]); not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_in  input  32  fetch address; bits [3:0] ignored (line aligned).
- rd_en  input  1  line request; sampled at a rising edge when the cache is accepting.
- abort  input  1  cancel any outstanding request (redirect).
- dout  output  128  line data; word k (address line_base+4k) is on dout[32k+31:32k].
- dout_valid  output  1  dout holds the line for the last accepted, un-aborted request.
- mem_addr  output  32  word address of the current refill beat: {line_base, beat, 2'b00}.
- mem_rd_en  output  1  refill word request; held until mem_rdata_valid.
- mem_rdata  input  32  refill word.
- mem_rdata_valid  input  1  mem_rdata valid; completes the current beat.

Behaviour:
- Storage: tag array, data array, one valid bit per line. All are flops, read combinationally at the sampling edge.
- Index is pc[3+INDEX_BITS:4].
- Reset, asynchronous:
  - All valid bits cleared.
  - State to IDLE.
  - dout_valid=0, dout=0, mem_rd_en=0, mem_addr=0, beat counter=0, abort_pending=0.
  - Reset mid-refill abandons the refill immediately; the partial line is never marked valid.
- State IDLE:
  - The request is accepted when rd_en=1, abort=0 and resp_r=0.
  - Accept on a hit: the line is loaded into dout_r and resp_r is set. dout_valid is high in the next cycle, giving 1-cycle hit latency. Stay in IDLE.
  - Accept on a miss: latch line_base=pc_in[31:4], beat=0, enter REFILL.
  - resp_r is cleared every cycle in which it was set. A new request therefore cannot be accepted in the cycle dout_valid is high; this prevents a duplicate response while the requester advances its pc. Peak throughput is one line per 2 cycles.
- State REFILL:
  - mem_rd_en=1 and mem_addr={line_base, beat, 2'b00}.
  - On mem_rdata_valid, the word is written into line buffer slot beat and beat increments.
  - On the 4th word (beat==3):
    - The tag and data arrays are written and the valid bit is set.
    - If abort_pending=0, dout_r is loaded with the full line and resp_r is set.
    - abort_pending is cleared and the state returns to IDLE.
  - mem_rd_en drops in the cycle after the last beat.
  - rd_en and pc_in are ignored in REFILL.
- Abort:
  - abort=1 in IDLE: no request is accepted that edge.
  - abort=1 in REFILL: abort_pending is set. The refill still completes and the line is installed, but no response is produced.
  - dout_valid = resp_r & ~abort, combinational mask. A response coinciding with abort is dropped and not replayed.
  - abort and mem_rdata_valid on the final beat together: the line is installed, no response.
- Replacement: direct-mapped; a refill overwrites the indexed line unconditionally.
- dout holds its last value when dout_valid=0.

Test Plan:
- Memory model:
  - Returns mem_rdata = mem_addr ^ 32'hA5A5A5A5.
  - mem_rdata_valid is asserted 3 cycles after mem_rd_en rises for each beat.
- Cold miss:
  - Stimulus: reset, then rd_en=1, pc_in=32'h0000_0040.
  - Required: mem_addr sequence 40, 44, 48, 4C.
  - Required: dout_valid=1 for exactly one cycle, one cycle after the 4th beat completes.
  - Required: dout = {4C^A5A5A5A5, 48^.., 44^.., 40^..}.
- Hit:
  - Stimulus: re-request 32'h0000_004C.
  - Required: dout_valid one cycle after acceptance, same line data, mem_rd_en stays 0.
  - Required: with rd_en held high, the next acceptance occurs only after the dout_valid cycle.
- Abort during refill:
  - Stimulus: miss on 32'h0000_0100, abort pulsed during beat 1.
  - Required: all 4 beats complete and dout_valid never rises.
  - Required: a later request to 32'h0000_0100 hits, with 1-cycle latency and no mem traffic.
- Abort coincident with a hit response:
  - Required: dout_valid=0 that cycle.
  - Required: a request to 32'h0000_0200 presented with abort=0 on the next edge is accepted normally.
- Conflict eviction, INDEX_BITS=6:
  - Stimulus: load 32'h0000_0040, then 32'h0000_0440 (same index, different tag), then 32'h0000_0040 again.
  - Required: each access is a miss with a full 4-beat refill.
- Reset mid-refill:
  - Stimulus: assert rst during beat 2 of the miss on 32'h0000_0300.
  - Required: mem_rd_en=0 immediately.
  - Required: after release, a request to 32'h0000_0300 misses (line not valid).

Source files
------------

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with 4-beat word refill
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  input  logic         rd_en,
  input  logic         abort,
  output logic [127:0] dout,
  output logic         dout_valid,
  output logic [31:0]  mem_addr,
  output logic         mem_rd_en,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rdata_valid
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Line storage; only the valid bits need a reset value.
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];
  logic [LINES-1:0]    valid_bits;

  // Refill context
  logic [27:0]         line_base;
  logic [1:0]          beat;
  logic [31:0]         line_buf [4];
  logic                abort_pending;

  // Response register
  logic [127:0]        dout_r;
  logic                resp_r;

  // Request decode
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  accept;
  logic                  beat_done;
  logic                  last_beat;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          fill_line;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^pc_in[3:0];

  assign req_index  = pc_in[3+INDEX_BITS:4];
  assign req_tag    = pc_in[31:4+INDEX_BITS];
  assign hit        = valid_bits[req_index] && (tag_mem[req_index] == req_tag);

  // resp_r blocks acceptance so the requester gets one response per pc
  // even if it keeps rd_en high while it advances.
  assign accept     = (state == IDLE) && rd_en && !abort && !resp_r;

  assign beat_done  = (state == REFILL) && mem_rdata_valid;
  assign last_beat  = beat_done && (beat == 2'd3);

  assign fill_index = line_base[INDEX_BITS-1:0];
  assign fill_tag   = line_base[27:INDEX_BITS];
  // The final word goes straight from the memory bus into the line.
  assign fill_line  = {mem_rdata, line_buf[2], line_buf[1], line_buf[0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: misses start a refill, the fourth beat ends it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !hit) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: memory request is held for the whole refill
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = {line_base, beat, 2'b00};
    case (state)
      IDLE:    mem_rd_en = 1'b0;
      REFILL:  mem_rd_en = 1'b1;
      default: mem_rd_en = 1'b0;
    endcase
  end

  // A response is dropped, not delayed, when abort coincides with it.
  assign dout_valid = resp_r & ~abort;
  assign dout       = dout_r;

  // Refill context, response register and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_base     <= '0;
      beat          <= '0;
      abort_pending <= 1'b0;
      resp_r        <= 1'b0;
      dout_r        <= '0;
      valid_bits    <= '0;
      for (int i = 0; i < 4; i++) begin
        line_buf[i] <= '0;
      end
    end else begin
      resp_r <= 1'b0;

      if (accept) begin
        if (hit) begin
          dout_r <= data_mem[req_index];
          resp_r <= 1'b1;
        end else begin
          line_base <= pc_in[31:4];
          beat      <= 2'd0;
        end
      end

      if (state == REFILL && abort && !last_beat) begin
        abort_pending <= 1'b1;
      end

      if (beat_done) begin
        line_buf[beat] <= mem_rdata;
        beat           <= beat + 2'd1;
      end

      if (last_beat) begin
        valid_bits[fill_index] <= 1'b1;
        abort_pending          <= 1'b0;
        // An abort arriving with the last word also suppresses the response.
        if (!abort_pending && !abort) begin
          dout_r <= fill_line;
          resp_r <= 1'b1;
        end
      end
    end
  end

  // Tag and data arrays are written once per completed refill
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_line;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard testbench for icache
module tb_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  pc_in = '0;
  logic         rd_en = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] dout;
  logic         dout_valid;
  logic [31:0]  mem_addr;
  logic         mem_rd_en;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rdata_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcnt = 0;
  int beats_seen = 0;
  int last_beat_cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           exp_cyc;
    bit           miss;
  } resp_t;

  resp_t       exp_resp [$];
  logic [31:0] exp_mem  [$];

  icache #(.INDEX_BITS(6)) dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .rd_en(rd_en),
    .abort(abort),
    .dout(dout),
    .dout_valid(dout_valid),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] line_of(input logic [31:0] pc);
    logic [127:0] r;
    logic [31:0]  base;
    base = {pc[31:4], 4'h0};
    for (int k = 0; k < 4; k++) begin
      r[32*k +: 32] = (base + 32'(4*k)) ^ 32'hA5A5A5A5;
    end
    return r;
  endfunction

  // Memory model: one word per beat, valid three cycles into each beat
  always @(negedge clk) begin
    if (rst || !mem_rd_en) begin
      mem_rdata_valid = 1'b0;
      mcnt = 0;
    end else if (mem_rdata_valid) begin
      mem_rdata_valid = 1'b0;
      mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt == 3) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = mem_addr ^ 32'hA5A5A5A5;
        beats_seen++;
        last_beat_cyc = cyc;
      end
    end
  end

  // Monitor: pops expected beats and responses as the DUT presents them
  always @(negedge clk) begin
    resp_t r;
    logic [31:0] a;
    #2;
    if (!rst) begin
      if (mem_rd_en) begin
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_traffic got mem_rd_en=1 addr=%h required mem_rd_en=0", mem_addr);
        end
      end
      if (mem_rdata_valid && exp_mem.size() != 0) begin
        a = exp_mem.pop_front();
        checks++;
        if (mem_addr !== a) begin
          errors++;
          $display("FAIL mem_addr got %h required %h", mem_addr, a);
        end
      end
      if (dout_valid) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got dout_valid=1 dout=%h required dout_valid=0", dout);
        end else begin
          r = exp_resp.pop_front();
          if (dout !== r.data) begin
            errors++;
            $display("FAIL resp_data got %h required %h", dout, r.data);
          end
          checks++;
          if (r.miss ? (cyc != last_beat_cyc + 1) : (cyc != r.exp_cyc)) begin
            errors++;
            $display("FAIL resp_latency got cycle %0d required %0d", cyc,
                     r.miss ? last_beat_cyc + 1 : r.exp_cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic wait_quiet();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #3;
      if (exp_resp.size() == 0 && exp_mem.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got resp=%0d mem=%0d pending required 0", exp_resp.size(), exp_mem.size());
      exp_resp.delete();
      exp_mem.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic push_beats(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) exp_mem.push_back({pc[31:4], 4'h0} + 32'(4*k));
  endtask

  // Called just after a negedge with the cache idle.
  task automatic do_miss(input logic [31:0] pc);
    resp_t r;
    r.data = line_of(pc); r.exp_cyc = 0; r.miss = 1;
    push_beats(pc);
    exp_resp.push_back(r);
    rd_en = 1'b1; pc_in = pc;
    @(negedge clk);
    rd_en = 1'b0;
    wait_quiet();
  endtask

  task automatic do_hit(input logic [31:0] pc);
    resp_t r;
    r.data = line_of(pc); r.exp_cyc = cyc + 1; r.miss = 0;
    exp_resp.push_back(r);
    rd_en = 1'b1; pc_in = pc;
    @(negedge clk);
    rd_en = 1'b0;
    wait_quiet();
  endtask

  task automatic wait_beats(input int target);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (beats_seen >= target) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat_wait got %0d beats required %0d", beats_seen, target);
    end
    @(negedge clk);
  endtask

  initial begin
    resp_t r;
    int c;
    int b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dout_valid", 128'(dout_valid), 128'(0));
    check("reset_dout", dout, 128'(0));
    check("reset_mem_rd_en", 128'(mem_rd_en), 128'(0));
    check("reset_mem_addr", 128'(mem_addr), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Cold miss then hit in the same line
    do_miss(32'h0000_0040);
    do_hit(32'h0000_004C);

    // rd_en held high: accepted every other cycle
    c = cyc;
    r.data = line_of(32'h0000_004C); r.miss = 0;
    r.exp_cyc = c + 1; exp_resp.push_back(r);
    r.exp_cyc = c + 3; exp_resp.push_back(r);
    rd_en = 1'b1; pc_in = 32'h0000_004C;
    repeat (4) @(negedge clk);
    rd_en = 1'b0;
    wait_quiet();

    // Abort during beat 1: refill completes silently
    b0 = beats_seen;
    push_beats(32'h0000_0100);
    rd_en = 1'b1; pc_in = 32'h0000_0100;
    @(negedge clk);
    rd_en = 1'b0;
    wait_beats(b0 + 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_quiet();
    check("abort_dout_held", dout, line_of(32'h0000_0040));
    do_hit(32'h0000_0100);

    // Abort coincident with a hit response, then a request on the next edge
    rd_en = 1'b1; pc_in = 32'h0000_0100;
    @(negedge clk);
    rd_en = 1'b0; abort = 1'b1;
    #1;
    check("abort_masks_valid", 128'(dout_valid), 128'(0));
    @(negedge clk);
    abort = 1'b0;
    do_miss(32'h0000_0200);

    // Reset during beat 2
    b0 = beats_seen;
    push_beats(32'h0000_0300);
    rd_en = 1'b1; pc_in = 32'h0000_0300;
    @(negedge clk);
    rd_en = 1'b0;
    wait_beats(b0 + 2);
    rst = 1'b1;
    exp_mem.delete();
    #1;
    check("rst_mem_rd_en", 128'(mem_rd_en), 128'(0));
    check("rst_dout_valid", 128'(dout_valid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_miss(32'h0000_0300);

    // Conflict eviction on index 4
    do_miss(32'h0000_0040);
    do_miss(32'h0000_0440);
    do_miss(32'h0000_0040);

    check("final_resp_queue", 128'(exp_resp.size()), 128'(0));
    check("final_mem_queue", 128'(exp_mem.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
